// File: rtl/icache_line_fill.sv
// rtl/icache_line_fill.sv - instruction cache line-fill engine
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   ADDR_FROM_CACHE_VALID     one-cycle miss request pulse
//   ADDR_FROM_CACHE           line address (byte address >> offset_width)
//   DATA_TO_CACHE             assembled line, word k at [k*data_width +: data_width]
//   DATA_TO_CACHE_VALID       one-cycle strobe, line complete
//   BUSY                      fill in progress
//   MEM_RD_EN/MEM_ADDR        word read request and its byte address
//   MEM_RD_READY              memory accepts the request this cycle
//   MEM_RD_DATA(_VALID)       in-order read responses
module icache_line_fill #(
  parameter int  data_width    = 32,
  parameter int  address_width = 32,
  parameter int  block_size    = 8,
  localparam int offset_width  = $clog2(data_width * block_size / 8),
  localparam int line_width    = block_size * data_width
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              ADDR_FROM_CACHE_VALID,
  input  logic [address_width-offset_width-1:0] ADDR_FROM_CACHE,
  output logic [line_width-1:0]             DATA_TO_CACHE,
  output logic                              DATA_TO_CACHE_VALID,
  output logic                              BUSY,
  output logic                              MEM_RD_EN,
  output logic [address_width-1:0]          MEM_ADDR,
  input  logic                              MEM_RD_READY,
  input  logic [data_width-1:0]             MEM_RD_DATA,
  input  logic                              MEM_RD_DATA_VALID
);

  localparam int idx_w  = $clog2(block_size);
  localparam int cnt_w  = idx_w + 1;
  localparam int byte_w = offset_width - idx_w;
  localparam logic [cnt_w-1:0] blk_cnt  = cnt_w'(block_size);
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(block_size - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t                                state_q, state_d;
  logic [address_width-offset_width-1:0] line_addr_q, line_addr_d;
  logic [cnt_w-1:0]                      issue_cnt_q, issue_cnt_d;
  logic [cnt_w-1:0]                      recv_cnt_q, recv_cnt_d;
  logic [line_width-1:0]                 line_q, line_d;
  logic                                  rd_en;
  logic                                  beat_in;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      line_q      <= line_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    line_d      = line_q;
    // Issue and receive sides run independently; up to block_size reads in flight.
    rd_en       = (state_q == FETCH) && (issue_cnt_q < blk_cnt);
    beat_in     = (state_q == FETCH) && MEM_RD_DATA_VALID && (recv_cnt_q < blk_cnt);

    case (state_q)
      IDLE: begin
        if (ADDR_FROM_CACHE_VALID) begin
          line_addr_d = ADDR_FROM_CACHE;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (rd_en && MEM_RD_READY) begin
          issue_cnt_d = issue_cnt_q + cnt_w'(1);
        end
        if (beat_in) begin
          line_d[recv_cnt_q[idx_w-1:0]*data_width +: data_width] = MEM_RD_DATA;
          recv_cnt_d = recv_cnt_q + cnt_w'(1);
          if (recv_cnt_q == last_cnt) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Words always run from line offset 0 upward; the address is held while
  // the issue counter is stalled by MEM_RD_READY.
  assign MEM_RD_EN           = rd_en;
  assign MEM_ADDR            = {line_addr_q, issue_cnt_q[idx_w-1:0], {byte_w{1'b0}}};
  assign DATA_TO_CACHE       = line_q;
  assign DATA_TO_CACHE_VALID = (state_q == DONE);
  assign BUSY                = (state_q != IDLE);

endmodule

// File: tb/tb_icache_line_fill.sv
// tb/tb_icache_line_fill.sv - directed table-driven bench for icache_line_fill
module tb_icache_line_fill;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int BS  = 8;
  localparam int OW  = 5;
  localparam int LW  = BS * DW;
  localparam int LAW = AW - OW;

  logic           CLK = 1'b0;
  logic           RST;
  logic           ADDR_FROM_CACHE_VALID;
  logic [LAW-1:0] ADDR_FROM_CACHE;
  logic [LW-1:0]  DATA_TO_CACHE;
  logic           DATA_TO_CACHE_VALID;
  logic           BUSY;
  logic           MEM_RD_EN;
  logic [AW-1:0]  MEM_ADDR;
  logic           MEM_RD_READY;
  logic [DW-1:0]  MEM_RD_DATA;
  logic           MEM_RD_DATA_VALID;

  always #5 CLK = ~CLK;

  icache_line_fill #(
    .data_width   (DW),
    .address_width(AW),
    .block_size   (BS)
  ) dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .ADDR_FROM_CACHE_VALID(ADDR_FROM_CACHE_VALID),
    .ADDR_FROM_CACHE      (ADDR_FROM_CACHE),
    .DATA_TO_CACHE        (DATA_TO_CACHE),
    .DATA_TO_CACHE_VALID  (DATA_TO_CACHE_VALID),
    .BUSY                 (BUSY),
    .MEM_RD_EN            (MEM_RD_EN),
    .MEM_ADDR             (MEM_ADDR),
    .MEM_RD_READY         (MEM_RD_READY),
    .MEM_RD_DATA          (MEM_RD_DATA),
    .MEM_RD_DATA_VALID    (MEM_RD_DATA_VALID)
  );

  typedef struct {
    logic [LAW-1:0] la;
    bit             alt;
    int             lat;
    logic [31:0]    seed;
    int             dup;
    int             exp_strobe;
    string          tag;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          gcyc  = 0;
  int          lat   = 1;
  bit          alt   = 1'b0;
  logic [31:0] seed  = 32'h0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] issued[$];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr  = 32'h0;
  int          stall_err  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle's inputs and models an always-in-order memory with fixed latency.
  task automatic drive(input bit req, input logic [LAW-1:0] la, input bit rst, input int rel);
    bit rdy;
    RST                   = rst;
    ADDR_FROM_CACHE_VALID = req;
    ADDR_FROM_CACHE       = req ? la : LAW'($urandom);
    rdy                   = alt ? ((rel % 2) == 0) : 1'b1;
    MEM_RD_READY          = rdy;
    if (q_due.size() > 0 && q_due[0] == gcyc) begin
      MEM_RD_DATA_VALID = 1'b1;
      MEM_RD_DATA       = seed + ((q_addr[0] >> 2) & 32'h7);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      MEM_RD_DATA_VALID = 1'b0;
      MEM_RD_DATA       = $urandom;
    end
    if (MEM_RD_EN && rdy) begin
      issued.push_back(MEM_ADDR);
      q_addr.push_back(MEM_ADDR);
      q_due.push_back(gcyc + lat);
    end
    prev_stall = MEM_RD_EN && !rdy;
    prev_addr  = MEM_ADDR;
    if (rst) begin
      q_addr.delete();
      q_due.delete();
    end
    gcyc++;
  endtask

  task automatic run_fill(input logic [LAW-1:0] la, input bit alt_i, input int lat_i,
                          input logic [31:0] seed_i, input int dup_cyc, input int exp_strobe,
                          input string tag);
    int          strobe_cyc;
    int          strobes;
    int          busy_cnt;
    logic [LW-1:0] got;
    logic [31:0] a;
    logic [31:0] base;
    strobe_cyc = -1;
    strobes    = 0;
    busy_cnt   = 0;
    got        = '0;
    alt        = alt_i;
    lat        = lat_i;
    seed       = seed_i;
    base       = {la, 5'b00000};
    issued.delete();
    stall_err  = 0;
    prev_stall = 1'b0;
    for (int rel = 0; rel <= 60; rel++) begin
      @(negedge CLK);
      if (rel == 0) begin
        check({tag, "_idle_busy"}, 64'(BUSY), 64'd0);
        check({tag, "_idle_en"}, 64'(MEM_RD_EN), 64'd0);
        check({tag, "_idle_strobe"}, 64'(DATA_TO_CACHE_VALID), 64'd0);
      end else begin
        if (prev_stall && (MEM_RD_EN !== 1'b1 || MEM_ADDR !== prev_addr)) stall_err++;
        if (BUSY) busy_cnt++;
        if (rel == 1) check({tag, "_en_cycle1"}, 64'(MEM_RD_EN), 64'd1);
        if (DATA_TO_CACHE_VALID) begin
          strobes++;
          strobe_cyc = rel;
          got        = DATA_TO_CACHE;
        end
      end
      drive((rel == 0) || (dup_cyc > 0 && rel == dup_cyc),
            (rel == 0) ? la : LAW'(27'h99), 1'b0, rel);
      if (strobes > 0) break;
    end
    check({tag, "_strobe_cycle"}, 64'(strobe_cyc), 64'(exp_strobe));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_strobe));
    check({tag, "_addr_stall"}, 64'(stall_err), 64'd0);
    check({tag, "_beats"}, 64'(issued.size()), 64'(BS));
    for (int k = 0; k < BS; k++) begin
      a = (k < issued.size()) ? issued[k] : 32'hDEAD_BEEF;
      check($sformatf("%s_addr%0d", tag, k), 64'(a), 64'(base + 32'(4 * k)));
      check($sformatf("%s_word%0d", tag, k), 64'(got[k*DW +: DW]), 64'(seed_i + 32'(k)));
    end
  endtask

  initial begin
    vec_t vecs[5];
    int   strobes;
    int   busy_cnt;
    int   en_cnt;

    vecs[0] = '{la: 27'h40,      alt: 1'b0, lat: 1, seed: 32'h0000_1000, dup: 0, exp_strobe: 10, tag: "basic"};
    vecs[1] = '{la: 27'h40,      alt: 1'b1, lat: 3, seed: 32'h0000_2000, dup: 0, exp_strobe: 20, tag: "bp"};
    vecs[2] = '{la: 27'h40,      alt: 1'b0, lat: 1, seed: 32'h0000_3000, dup: 4, exp_strobe: 10, tag: "dupreq"};
    vecs[3] = '{la: 27'h7,       alt: 1'b0, lat: 2, seed: 32'h0000_A000, dup: 0, exp_strobe: 11, tag: "lat2"};
    vecs[4] = '{la: 27'h7FFFFFF, alt: 1'b0, lat: 8, seed: 32'h5A5A_0000, dup: 0, exp_strobe: 17, tag: "lat8"};

    RST                   = 1'b1;
    ADDR_FROM_CACHE_VALID = 1'($urandom);
    ADDR_FROM_CACHE       = LAW'($urandom);
    MEM_RD_READY          = 1'($urandom);
    MEM_RD_DATA           = $urandom;
    MEM_RD_DATA_VALID     = 1'($urandom);
    @(posedge CLK);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check("rst_line", 64'(DATA_TO_CACHE != '0), 64'd0);
      check("rst_strobe", 64'(DATA_TO_CACHE_VALID), 64'd0);
      check("rst_busy", 64'(BUSY), 64'd0);
      check("rst_en", 64'(MEM_RD_EN), 64'd0);
      check("rst_addr", 64'(MEM_ADDR), 64'd0);
      ADDR_FROM_CACHE_VALID = 1'($urandom);
      ADDR_FROM_CACHE       = LAW'($urandom);
      MEM_RD_READY          = 1'($urandom);
      MEM_RD_DATA           = $urandom;
      MEM_RD_DATA_VALID     = 1'($urandom);
    end

    // Consecutive fills start in the first IDLE cycle after the previous strobe.
    for (int v = 0; v < 5; v++) begin
      run_fill(vecs[v].la, vecs[v].alt, vecs[v].lat, vecs[v].seed,
               vecs[v].dup, vecs[v].exp_strobe, vecs[v].tag);
    end

    alt  = 1'b0;
    lat  = 1;
    seed = 32'h0000_BAD0;
    for (int rel = 0; rel <= 5; rel++) begin
      @(negedge CLK);
      drive(rel == 0, 27'h40, rel == 5, rel);
    end
    strobes  = 0;
    busy_cnt = 0;
    en_cnt   = 0;
    for (int rel = 6; rel <= 20; rel++) begin
      @(negedge CLK);
      strobes  += int'(DATA_TO_CACHE_VALID);
      busy_cnt += int'(BUSY);
      en_cnt   += int'(MEM_RD_EN);
      drive(1'b0, '0, 1'b0, rel);
    end
    check("midrst_no_strobe", 64'(strobes), 64'd0);
    check("midrst_no_busy", 64'(busy_cnt), 64'd0);
    check("midrst_no_en", 64'(en_cnt), 64'd0);
    check("midrst_line_cleared", 64'(DATA_TO_CACHE != '0), 64'd0);

    run_fill(27'h7, 1'b0, 1, 32'h0000_C000, 0, 10, "after_rst");

    en_cnt   = 0;
    busy_cnt = 0;
    for (int rel = 0; rel < 4; rel++) begin
      @(negedge CLK);
      en_cnt   += int'(MEM_RD_EN);
      busy_cnt += int'(BUSY);
      drive(1'b0, '0, 1'b0, rel);
    end
    check("final_idle_en", 64'(en_cnt), 64'd0);
    check("final_idle_busy", 64'(busy_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
